// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types: branch resolve queue entry state, entry record
// and the mispredict rule applied when an entry retires.
package rv32i_types;

    typedef enum logic [1:0] {
        BRQ_EMPTY    = 2'd0,
        BRQ_PENDING  = 2'd1,
        BRQ_RESOLVED = 2'd2
    } brq_state_t;

    typedef struct packed {
        brq_state_t  state;
        logic [31:0] pc;
        logic        pred_taken;
        logic [31:0] pred_addr;
        logic        act_taken;
        logic [31:0] act_target;
    } brq_entry_t;

    // Wrong direction, or right "taken" direction with the wrong target.
    function automatic logic brq_mispredict(input brq_entry_t e);
        return (e.pred_taken != e.act_taken) ||
               (e.pred_taken && e.act_taken && (e.pred_addr != e.act_target));
    endfunction

endpackage

// File: rtl/br_resolve_queue.sv
// In-order queue of predicted branches: allocated by fetch, resolved out of order
// by execute, retired in order to train the predictor. Optional: BRQ_STATS_EN.
module br_resolve_queue
    import rv32i_types::*;
#(
    parameter int DEPTH = 8,               // power of 2, >= 2
    parameter int TAG_W = $clog2(DEPTH)    // derived; do not override
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alloc_valid,
    input  logic [31:0]      alloc_pc,
    input  logic             alloc_pred_taken,
    input  logic [31:0]      alloc_pred_addr,
    output logic             alloc_ready,
    output logic [TAG_W-1:0] alloc_tag,
    input  logic             res_valid,
    input  logic [TAG_W-1:0] res_tag,
    input  logic             res_taken,
    input  logic [31:0]      res_target,
    output logic             upd_valid,
    output logic [31:0]      upd_pc,
    output logic             upd_taken,
    output logic [31:0]      upd_target,
    output logic             flush,
    output logic [31:0]      redirect_pc,
`ifdef BRQ_STATS_EN
    output logic [31:0]      retire_cnt,
    output logic [31:0]      mispred_cnt,
`endif
    output logic [TAG_W:0]   count
);

    localparam int PTR_W = TAG_W + 1;

    brq_entry_t       entries_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [TAG_W-1:0] head_idx, tail_idx;
    logic [PTR_W-1:0] count_w;
    brq_entry_t       head_entry;
    logic             retire, mispred, alloc_fire, res_fire;

    logic             upd_valid_q, upd_valid_d;
    logic [31:0]      upd_pc_q, upd_pc_d;
    logic             upd_taken_q, upd_taken_d;
    logic [31:0]      upd_target_q, upd_target_d;
    logic             flush_q, flush_d;
    logic [31:0]      redirect_pc_q, redirect_pc_d;

    // Pointers carry a wrap bit, so tail - head is the occupancy directly.
    assign head_idx   = head_q[TAG_W-1:0];
    assign tail_idx   = tail_q[TAG_W-1:0];
    assign count_w    = tail_q - head_q;
    assign head_entry = entries_q[head_idx];

    assign retire     = (head_entry.state == BRQ_RESOLVED);
    assign mispred    = retire && brq_mispredict(head_entry);
    assign alloc_fire = alloc_valid && alloc_ready && !mispred;
    assign res_fire   = res_valid && (entries_q[res_tag].state == BRQ_PENDING) && !mispred;

    assign alloc_ready = (count_w != PTR_W'(DEPTH));
    assign alloc_tag   = tail_idx;
    assign count       = count_w;

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path infers a latch.
        head_d        = head_q;
        tail_d        = tail_q;
        upd_valid_d   = retire;
        upd_pc_d      = upd_pc_q;
        upd_taken_d   = upd_taken_q;
        upd_target_d  = upd_target_q;
        flush_d       = mispred;
        redirect_pc_d = redirect_pc_q;

        if (retire) begin
            upd_pc_d     = head_entry.pc;
            upd_taken_d  = head_entry.act_taken;
            upd_target_d = head_entry.act_target;
        end

        if (mispred) begin
            redirect_pc_d = head_entry.act_taken ? head_entry.act_target
                                                 : head_entry.pc + 32'd4;
            head_d = '0;
            tail_d = '0;
        end else begin
            if (retire)     head_d = head_q + PTR_W'(1);
            if (alloc_fire) tail_d = tail_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            head_q        <= '0;
            tail_q        <= '0;
            upd_valid_q   <= 1'b0;
            upd_pc_q      <= '0;
            upd_taken_q   <= 1'b0;
            upd_target_q  <= '0;
            flush_q       <= 1'b0;
            redirect_pc_q <= '0;
        end else begin
            head_q        <= head_d;
            tail_q        <= tail_d;
            upd_valid_q   <= upd_valid_d;
            upd_pc_q      <= upd_pc_d;
            upd_taken_q   <= upd_taken_d;
            upd_target_q  <= upd_target_d;
            flush_q       <= flush_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: only the state field is reset; payload is never read while an entry is EMPTY.
        if (rst || mispred) begin
            for (int i = 0; i < DEPTH; i++) entries_q[i].state <= BRQ_EMPTY;
        end else begin
            if (retire) entries_q[head_idx].state <= BRQ_EMPTY;
            if (res_fire) begin
                entries_q[res_tag].state      <= BRQ_RESOLVED;
                entries_q[res_tag].act_taken  <= res_taken;
                entries_q[res_tag].act_target <= res_target;
            end
            if (alloc_fire) begin
                entries_q[tail_idx] <= '{state:      BRQ_PENDING,
                                         pc:         alloc_pc,
                                         pred_taken: alloc_pred_taken,
                                         pred_addr:  alloc_pred_addr,
                                         act_taken:  1'b0,
                                         act_target: 32'd0};
            end
        end
    end

    assign upd_valid   = upd_valid_q;
    assign upd_pc      = upd_pc_q;
    assign upd_taken   = upd_taken_q;
    assign upd_target  = upd_target_q;
    assign flush       = flush_q;
    assign redirect_pc = redirect_pc_q;

`ifdef BRQ_STATS_EN
    logic [31:0] retire_cnt_q, mispred_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            retire_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            if (retire)  retire_cnt_q  <= retire_cnt_q + 32'd1;
            if (mispred) mispred_cnt_q <= mispred_cnt_q + 32'd1;
        end
    end

    assign retire_cnt  = retire_cnt_q;
    assign mispred_cnt = mispred_cnt_q;
`endif

endmodule
